// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard/stall controller:
// FSM state encoding, parameter defaults and the register-match helper.
package hazard_stall_ctrl_pkg;

   // Controller states, 2-bit encoding shared by the top and any observers.
   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,   // normal issue, per-cycle hazard checks
      ST_DRAIN = 2'b01,   // SYSCALL held in ID while older instrs retire
      ST_ISSUE = 2'b10,   // SYSCALL released into ID_EXE for one cycle
      ST_HALT  = 2'b11    // fetch frozen until the service routine resumes
   } state_e;

   // Older instructions to retire (EXE, MEM, WB) before SYSCALL issues.
   localparam int DRAIN_CYCLES_DEF = 3;

   // Default width of the debug stall-cycle counter.
   localparam int STALL_CNT_W_DEF  = 16;

   // Register $0 is hard-wired to zero, so it never carries a dependency.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // True when a source operand is actually read and names the load destination.
   function automatic logic src_hit(input logic       uses,
                                    input logic [4:0] src,
                                    input logic [4:0] dst);
      return uses && (src == dst);
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones,
// cleared asynchronously by an active-low reset.
module hazard_stall_ctrl_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             at_max_s;

   // Saturation detect: all ones means the counter must hold.
   always_comb begin
      at_max_s = (count_q == {WIDTH{1'b1}});
   end

   // Next count: add one only when requested and not yet saturated.
   always_comb begin
      count_d = count_q;
      if (inc_i && !at_max_s) begin
         count_d = count_q + WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= {WIDTH{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller between decode (IF_ID + decoder) and ID_EXE.
// Inserts one bubble on a load-use dependency, flushes IF_ID on a taken branch
// resolved in EXE, and drains / issues / halts around SYSCALL. Enables are
// combinational from state and inputs; state and counters are registered.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int STALL_CNT_W  = STALL_CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   idValid,
   input  logic [4:0]             idRs,
   input  logic [4:0]             idRt,
   input  logic                   idUsesRs,
   input  logic                   idUsesRt,
   input  logic                   idSyscall,
   input  logic                   exeMemRead,
   input  logic [4:0]             exeRt,
   input  logic                   exeBranchTaken,
   input  logic                   sysResume,
   output logic                   pcWrite,
   output logic                   ifIdWrite,
   output logic                   ifIdFlush,
   output logic                   idExeBubble,
   output logic                   halted,
   output logic [STALL_CNT_W-1:0] stallCycles
);

   // Drain counter counts DRAIN_CYCLES-1 down to 0; keep at least one bit.
   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

   state_e             state_q;
   state_e             state_d;
   logic [DRAIN_W-1:0] drain_cnt_q;
   logic [DRAIN_W-1:0] drain_cnt_d;

   logic load_use_s;
   logic pc_write_s;
   logic if_id_write_s;
   logic if_id_flush_s;
   logic bubble_s;
   logic halted_s;

   // Load-use detect: a load in EXE writes a register the ID instr reads.
   always_comb begin
      load_use_s = idValid && exeMemRead && (exeRt != REG_ZERO) &&
                   (src_hit(idUsesRs, idRs, exeRt) || src_hit(idUsesRt, idRt, exeRt));
   end

   // Next-state and enable decode; defaults hold PC/IF_ID and bubble ID_EXE.
   always_comb begin
      state_d       = state_q;
      drain_cnt_d   = drain_cnt_q;
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      if_id_flush_s = 1'b0;
      bubble_s      = 1'b1;
      halted_s      = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (exeBranchTaken) begin
               // Redirect wins over everything: the ID instr is on the wrong path.
               pc_write_s    = 1'b1;
               if_id_write_s = 1'b1;
               if_id_flush_s = 1'b1;
               bubble_s      = 1'b1;
            end else if (load_use_s) begin
               // One bubble lets the load reach MEM, where forwarding covers it.
               pc_write_s    = 1'b0;
               if_id_write_s = 1'b0;
               bubble_s      = 1'b1;
            end else if (idValid && idSyscall) begin
               pc_write_s    = 1'b0;
               if_id_write_s = 1'b0;
               bubble_s      = 1'b1;
               drain_cnt_d   = DRAIN_LOAD;
               state_d       = ST_DRAIN;
            end else begin
               pc_write_s    = 1'b1;
               if_id_write_s = 1'b1;
               bubble_s      = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (exeBranchTaken) begin
               // An older branch squashes the pending SYSCALL.
               pc_write_s    = 1'b1;
               if_id_write_s = 1'b1;
               if_id_flush_s = 1'b1;
               bubble_s      = 1'b1;
               drain_cnt_d   = {DRAIN_W{1'b0}};
               state_d       = ST_RUN;
            end else if (drain_cnt_q == {DRAIN_W{1'b0}}) begin
               state_d       = ST_ISSUE;
            end else begin
               drain_cnt_d   = drain_cnt_q - DRAIN_W'(1);
            end
         end
         ST_ISSUE: begin
            // EXE holds a bubble here, so a taken branch cannot appear.
            bubble_s = 1'b0;
            state_d  = ST_HALT;
         end
         ST_HALT: begin
            halted_s = 1'b1;
            if (sysResume) begin
               // Overwrite the stale SYSCALL in IF_ID; it must not reissue.
               pc_write_s    = 1'b1;
               if_id_write_s = 1'b1;
               bubble_s      = 1'b1;
               state_d       = ST_RUN;
            end else begin
               state_d = ST_HALT;
            end
         end
         default: begin
            state_d     = ST_RUN;
            drain_cnt_d = {DRAIN_W{1'b0}};
         end
      endcase
   end

   // State and drain counter; reset drops any partial drain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= {DRAIN_W{1'b0}};
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // While reset is low the pipeline is frozen and ID_EXE sees bubbles.
   assign pcWrite     = reset & pc_write_s;
   assign ifIdWrite   = reset & if_id_write_s;
   assign ifIdFlush   = reset & if_id_flush_s;
   assign idExeBubble = (~reset) | bubble_s;
   assign halted      = reset & halted_s;

   hazard_stall_ctrl_sat_counter #(
      .WIDTH (STALL_CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .rst_n   (reset),
      .inc_i   (~pcWrite),
      .count_o (stallCycles)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: each step drives inputs on the
// falling edge, pushes the expected outputs, samples 2 ns later and compares.
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        idValid = 1'b0;
   logic [4:0]  idRs = 5'd0;
   logic [4:0]  idRt = 5'd0;
   logic        idUsesRs = 1'b0;
   logic        idUsesRt = 1'b0;
   logic        idSyscall = 1'b0;
   logic        exeMemRead = 1'b0;
   logic [4:0]  exeRt = 5'd0;
   logic        exeBranchTaken = 1'b0;
   logic        sysResume = 1'b0;
   logic        pcWrite, ifIdWrite, ifIdFlush, idExeBubble, halted;
   logic [15:0] stallCycles;
   logic [4:0]  outs;

   assign outs = {pcWrite, ifIdWrite, ifIdFlush, idExeBubble, halted};

   // {pcWrite, ifIdWrite, ifIdFlush, idExeBubble, halted}
   localparam logic [4:0] O_RUN    = 5'b11000;
   localparam logic [4:0] O_STALL  = 5'b00010;
   localparam logic [4:0] O_FLUSH  = 5'b11110;
   localparam logic [4:0] O_ISSUE  = 5'b00000;
   localparam logic [4:0] O_HALT   = 5'b00011;
   localparam logic [4:0] O_RESUME = 5'b11011;

   typedef struct packed {
      logic       rst;
      logic       vld;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       sys;
      logic       mr;
      logic [4:0] ert;
      logic       br;
      logic       res;
   } in_t;

   typedef struct {
      string       tag;
      int          step;
      logic [4:0]  outs;
      logic [15:0] stall;
   } sb_t;

   sb_t         sb_q[$];
   logic [15:0] exp_stall = 16'd0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(
      .DRAIN_CYCLES (3),
      .STALL_CNT_W  (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .idValid        (idValid),
      .idRs           (idRs),
      .idRt           (idRt),
      .idUsesRs       (idUsesRs),
      .idUsesRt       (idUsesRt),
      .idSyscall      (idSyscall),
      .exeMemRead     (exeMemRead),
      .exeRt          (exeRt),
      .exeBranchTaken (exeBranchTaken),
      .sysResume      (sysResume),
      .pcWrite        (pcWrite),
      .ifIdWrite      (ifIdWrite),
      .ifIdFlush      (ifIdFlush),
      .idExeBubble    (idExeBubble),
      .halted         (halted),
      .stallCycles    (stallCycles)
   );

   function automatic in_t mk(input logic rst, input logic vld, input logic [4:0] rs,
                              input logic [4:0] rt, input logic urs, input logic urt,
                              input logic sys, input logic mr, input logic [4:0] ert,
                              input logic br, input logic res);
      in_t v;
      v = '{rst:rst, vld:vld, rs:rs, rt:rt, urs:urs, urt:urt, sys:sys,
            mr:mr, ert:ert, br:br, res:res};
      return v;
   endfunction

   function automatic in_t idle();
      return mk(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endfunction

   function automatic in_t sysc();
      return mk(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
   endfunction

   task automatic drive(input in_t v);
      @(negedge clk);
      reset          = v.rst;
      idValid        = v.vld;
      idRs           = v.rs;
      idRt           = v.rt;
      idUsesRs       = v.urs;
      idUsesRt       = v.urt;
      idSyscall      = v.sys;
      exeMemRead     = v.mr;
      exeRt          = v.ert;
      exeBranchTaken = v.br;
      sysResume      = v.res;
   endtask

   task automatic test_reset();
      in_t        ins[$]  = '{mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0),
                              mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0),
                              idle()};
      logic [4:0] exps[$] = '{O_STALL, O_STALL, O_RUN};
      sb_t        e;
      for (int i = 0; i < ins.size(); i++) begin
         drive(ins[i]);
         if (!ins[i].rst) exp_stall = 16'd0;
         sb_q.push_back('{tag:"reset", step:i, outs:exps[i], stall:exp_stall});
         #2;
         e = sb_q.pop_front();
         total++;
         if (outs !== e.outs) begin
            bad++;
            $display("FAIL %s[%0d] outs: got %b want %b", e.tag, e.step, outs, e.outs);
         end
         total++;
         if (stallCycles !== e.stall) begin
            bad++;
            $display("FAIL %s[%0d] stallCycles: got %0d want %0d", e.tag, e.step, stallCycles, e.stall);
         end
         if (ins[i].rst && !e.outs[4]) exp_stall++;
      end
   endtask

   task automatic test_load_use();
      // Rs hit, clear, Rt hit, Rt match unused, invalid ID, $0 destination, Rs hit via Rt field off.
      in_t        ins[$]  = '{mk(1'b1, 1'b1, 5'd8,  5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0),
                              mk(1'b1, 1'b1, 5'd8,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 5'd8,  1'b0, 1'b0),
                              mk(1'b1, 1'b1, 5'd4,  5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0),
                              mk(1'b1, 1'b1, 5'd4,  5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0),
                              mk(1'b1, 1'b0, 5'd9,  5'd9,  1'b1, 1'b1, 1'b0, 1'b1, 5'd9,  1'b0, 1'b0),
                              mk(1'b1, 1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0),
                              mk(1'b1, 1'b1, 5'd17, 5'd17, 1'b0, 1'b0, 1'b0, 1'b1, 5'd17, 1'b0, 1'b0),
                              mk(1'b1, 1'b1, 5'd31, 5'd1,  1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0)};
      logic [4:0] exps[$] = '{O_STALL, O_RUN, O_STALL, O_RUN, O_RUN, O_RUN, O_RUN, O_STALL};
      sb_t        e;
      for (int i = 0; i < ins.size(); i++) begin
         drive(ins[i]);
         sb_q.push_back('{tag:"load_use", step:i, outs:exps[i], stall:exp_stall});
         #2;
         e = sb_q.pop_front();
         total++;
         if (outs !== e.outs) begin
            bad++;
            $display("FAIL %s[%0d] outs: got %b want %b", e.tag, e.step, outs, e.outs);
         end
         total++;
         if (stallCycles !== e.stall) begin
            bad++;
            $display("FAIL %s[%0d] stallCycles: got %0d want %0d", e.tag, e.step, stallCycles, e.stall);
         end
         if (!e.outs[4]) exp_stall++;
      end
   endtask

   task automatic test_priority();
      // Branch with load-use, branch with syscall (stays in RUN), then normal.
      in_t        ins[$]  = '{mk(1'b1, 1'b1, 5'd8, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0),
                              mk(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0),
                              idle(), idle()};
      logic [4:0] exps[$] = '{O_FLUSH, O_FLUSH, O_RUN, O_RUN};
      sb_t        e;
      for (int i = 0; i < ins.size(); i++) begin
         drive(ins[i]);
         sb_q.push_back('{tag:"priority", step:i, outs:exps[i], stall:exp_stall});
         #2;
         e = sb_q.pop_front();
         total++;
         if (outs !== e.outs) begin
            bad++;
            $display("FAIL %s[%0d] outs: got %b want %b", e.tag, e.step, outs, e.outs);
         end
         total++;
         if (stallCycles !== e.stall) begin
            bad++;
            $display("FAIL %s[%0d] stallCycles: got %0d want %0d", e.tag, e.step, stallCycles, e.stall);
         end
         if (!e.outs[4]) exp_stall++;
      end
   endtask

   task automatic test_syscall();
      // Detect + 3 drain, issue (branch ignored), halt x2, resume, run.
      in_t        ins[$]  = '{sysc(), sysc(), sysc(), sysc(),
                              mk(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0),
                              sysc(), sysc(),
                              mk(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1),
                              idle(), idle()};
      logic [4:0] exps[$] = '{O_STALL, O_STALL, O_STALL, O_STALL, O_ISSUE,
                              O_HALT, O_HALT, O_RESUME, O_RUN, O_RUN};
      sb_t        e;
      for (int i = 0; i < ins.size(); i++) begin
         drive(ins[i]);
         sb_q.push_back('{tag:"syscall", step:i, outs:exps[i], stall:exp_stall});
         #2;
         e = sb_q.pop_front();
         total++;
         if (outs !== e.outs) begin
            bad++;
            $display("FAIL %s[%0d] outs: got %b want %b", e.tag, e.step, outs, e.outs);
         end
         total++;
         if (stallCycles !== e.stall) begin
            bad++;
            $display("FAIL %s[%0d] stallCycles: got %0d want %0d", e.tag, e.step, stallCycles, e.stall);
         end
         if (!e.outs[4]) exp_stall++;
      end
   endtask

   task automatic test_drain_branch();
      // Branch in the first DRAIN cycle squashes the syscall; never halts.
      in_t        ins[$]  = '{sysc(),
                              mk(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0),
                              idle(), idle(), idle(), idle(), idle()};
      logic [4:0] exps[$] = '{O_STALL, O_FLUSH, O_RUN, O_RUN, O_RUN, O_RUN, O_RUN};
      sb_t        e;
      for (int i = 0; i < ins.size(); i++) begin
         drive(ins[i]);
         sb_q.push_back('{tag:"drain_branch", step:i, outs:exps[i], stall:exp_stall});
         #2;
         e = sb_q.pop_front();
         total++;
         if (outs !== e.outs) begin
            bad++;
            $display("FAIL %s[%0d] outs: got %b want %b", e.tag, e.step, outs, e.outs);
         end
         total++;
         if (stallCycles !== e.stall) begin
            bad++;
            $display("FAIL %s[%0d] stallCycles: got %0d want %0d", e.tag, e.step, stallCycles, e.stall);
         end
         if (!e.outs[4]) exp_stall++;
      end
   endtask

   task automatic test_back_to_back();
      // Load-use, resolve, load-use again, then syscall straight after.
      in_t        ins[$]  = '{mk(1'b1, 1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0),
                              mk(1'b1, 1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0),
                              mk(1'b1, 1'b1, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0),
                              mk(1'b1, 1'b1, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0),
                              sysc(), sysc()};
      logic [4:0] exps[$] = '{O_STALL, O_RUN, O_STALL, O_RUN, O_STALL, O_STALL};
      sb_t        e;
      for (int i = 0; i < ins.size(); i++) begin
         drive(ins[i]);
         sb_q.push_back('{tag:"back_to_back", step:i, outs:exps[i], stall:exp_stall});
         #2;
         e = sb_q.pop_front();
         total++;
         if (outs !== e.outs) begin
            bad++;
            $display("FAIL %s[%0d] outs: got %b want %b", e.tag, e.step, outs, e.outs);
         end
         total++;
         if (stallCycles !== e.stall) begin
            bad++;
            $display("FAIL %s[%0d] stallCycles: got %0d want %0d", e.tag, e.step, stallCycles, e.stall);
         end
         if (!e.outs[4]) exp_stall++;
      end
   endtask

   task automatic test_reset_in_halt();
      // Still draining from the previous task: 2 more drain, issue, halt.
      in_t        ins[$]  = '{sysc(), sysc(), sysc(), sysc()};
      logic [4:0] exps[$] = '{O_STALL, O_STALL, O_ISSUE, O_HALT};
      sb_t        e;
      for (int i = 0; i < ins.size(); i++) begin
         drive(ins[i]);
         sb_q.push_back('{tag:"reset_in_halt", step:i, outs:exps[i], stall:exp_stall});
         #2;
         e = sb_q.pop_front();
         total++;
         if (outs !== e.outs) begin
            bad++;
            $display("FAIL %s[%0d] outs: got %b want %b", e.tag, e.step, outs, e.outs);
         end
         total++;
         if (stallCycles !== e.stall) begin
            bad++;
            $display("FAIL %s[%0d] stallCycles: got %0d want %0d", e.tag, e.step, stallCycles, e.stall);
         end
         if (!e.outs[4]) exp_stall++;
      end
      // Mid-cycle, no clock edge before the checks below.
      reset = 1'b0;
      exp_stall = 16'd0;
      #1;
      total++;
      if (halted !== 1'b0) begin
         bad++;
         $display("FAIL async_reset halted: got %b want 0", halted);
      end
      total++;
      if (outs !== O_STALL) begin
         bad++;
         $display("FAIL async_reset outs: got %b want %b", outs, O_STALL);
      end
      total++;
      if (stallCycles !== 16'd0) begin
         bad++;
         $display("FAIL async_reset stallCycles: got %0d want 0", stallCycles);
      end
      // Released with the syscall gone: plain RUN, no leftover drain.
      drive(idle());
      sb_q.push_back('{tag:"after_reset", step:0, outs:O_RUN, stall:exp_stall});
      #2;
      e = sb_q.pop_front();
      total++;
      if (outs !== e.outs) begin
         bad++;
         $display("FAIL %s[%0d] outs: got %b want %b", e.tag, e.step, outs, e.outs);
      end
      total++;
      if (stallCycles !== e.stall) begin
         bad++;
         $display("FAIL %s[%0d] stallCycles: got %0d want %0d", e.tag, e.step, stallCycles, e.stall);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_priority();
      test_syscall();
      test_drain_branch();
      test_back_to_back();
      test_reset_in_halt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
